// File: rtl/pc_flow_ctrl.sv
// Program-counter / return-address-stack sequencer between decoder and instruction memory.
// Optional feature macro: PCF_STACK_EN (DEPTH-entry LIFO RAS; otherwise a single saved-PC slot).
module pc_flow_ctrl #(
    parameter int AW    = 11,
    parameter int RW    = 10,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [RW-1:0] cmd_rel,
    output logic          fetch_req,
    output logic [AW-1:0] fetch_addr,
    input  logic          fetch_ack,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] pc_prev,
    output logic          fault,
    output logic          fault_ovf,
    output logic          fault_unf,
    input  logic          clear_fault
);

`ifdef PCF_STACK_EN
    localparam int CAP = DEPTH;
`else
    localparam int CAP = 1;
`endif
    localparam int SPW = $clog2(CAP + 1);

    localparam logic [1:0] OP_NEXT = 2'd0;
    localparam logic [1:0] OP_JUMP = 2'd1;
    localparam logic [1:0] OP_CALL = 2'd2;
    localparam logic [1:0] OP_RET  = 2'd3;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    // Modulo-2^AW address sum; the carry is intentionally discarded.
    function automatic logic [AW-1:0] pc_add(input logic [AW-1:0] base, input logic [AW-1:0] off);
        return base + off;
    endfunction

    state_t          state_r;
    state_t          state_nxt_s;
    logic [AW-1:0]   pc_r;
    logic [AW-1:0]   pc_nxt_s;
    logic [AW-1:0]   pc_prev_r;
    logic [AW-1:0]   pc_prev_nxt_s;
    logic [SPW-1:0]  sp_r;
    logic [SPW-1:0]  sp_nxt_s;
    logic [AW-1:0]   ras_r [CAP];
    logic [AW-1:0]   ret_addr_s;
    logic            push_s;
    logic            ovf_set_s;
    logic            unf_set_s;
    logic            fault_clr_s;
    logic            ras_full_s;
    logic            ras_empty_s;
    logic            fetch_req_r;
    logic            cmd_ready_r;
    logic            fault_r;
    logic            fault_ovf_r;
    logic            fault_unf_r;

    assign ras_full_s  = (sp_r == SPW'(CAP));
    assign ras_empty_s = (sp_r == {SPW{1'b0}});

    // Top-of-stack read as a one-hot AND-OR mux over the entries.
    always_comb begin
        ret_addr_s = {AW{1'b0}};
        for (int i = 0; i < CAP; i++) begin
            ret_addr_s = ret_addr_s | (ras_r[i] & {AW{sp_r == SPW'(i + 1)}});
        end
    end

    // Next-state, next-pc and stack/fault control decode.
    always_comb begin
        state_nxt_s   = state_r;
        pc_nxt_s      = pc_r;
        pc_prev_nxt_s = pc_prev_r;
        sp_nxt_s      = sp_r;
        push_s        = 1'b0;
        ovf_set_s     = 1'b0;
        unf_set_s     = 1'b0;
        fault_clr_s   = 1'b0;
        case (state_r)
            ST_BOOT: begin
                state_nxt_s = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (fetch_ack && fetch_req_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_NEXT: begin
                            pc_prev_nxt_s = pc_r;
                            pc_nxt_s      = pc_add(pc_r, {{(AW-1){1'b0}}, 1'b1});
                            state_nxt_s   = ST_ISSUE;
                        end
                        OP_JUMP: begin
                            pc_prev_nxt_s = pc_r;
                            pc_nxt_s      = cmd_addr;
                            state_nxt_s   = ST_ISSUE;
                        end
                        OP_CALL: begin
                            if (ras_full_s) begin
                                ovf_set_s   = 1'b1;
                                state_nxt_s = ST_FAULT;
                            end else begin
                                push_s        = 1'b1;
                                sp_nxt_s      = sp_r + SPW'(1);
                                pc_prev_nxt_s = pc_r;
                                pc_nxt_s      = pc_add(pc_r, AW'(cmd_rel));
                                state_nxt_s   = ST_ISSUE;
                            end
                        end
                        OP_RET: begin
                            if (ras_empty_s) begin
                                unf_set_s   = 1'b1;
                                state_nxt_s = ST_FAULT;
                            end else begin
                                sp_nxt_s      = sp_r - SPW'(1);
                                pc_prev_nxt_s = pc_r;
                                pc_nxt_s      = pc_add(ret_addr_s, {{(AW-1){1'b0}}, 1'b1});
                                state_nxt_s   = ST_ISSUE;
                            end
                        end
                        default: begin
                            state_nxt_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (clear_fault) begin
                    fault_clr_s = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_FAULT;
                end
            end
            default: begin
                state_nxt_s = ST_BOOT;
            end
        endcase
    end

    // State, pc and stack-pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_BOOT;
            pc_r      <= {AW{1'b0}};
            pc_prev_r <= {AW{1'b0}};
            sp_r      <= {SPW{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            pc_r      <= pc_nxt_s;
            pc_prev_r <= pc_prev_nxt_s;
            sp_r      <= sp_nxt_s;
        end
    end

    // Return-address storage; the pushed value is the pc before the CALL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CAP; i++) begin
                ras_r[i] <= {AW{1'b0}};
            end
        end else begin
            for (int i = 0; i < CAP; i++) begin
                if (push_s && (sp_r == SPW'(i))) begin
                    ras_r[i] <= pc_r;
                end
            end
        end
    end

    // Handshake outputs registered from the next state so they align with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_req_r <= 1'b0;
            cmd_ready_r <= 1'b0;
        end else begin
            fetch_req_r <= (state_nxt_s == ST_ISSUE);
            cmd_ready_r <= (state_nxt_s == ST_IDLE);
        end
    end

    // Sticky fault flags, cleared only when leaving FAULT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_r     <= 1'b0;
            fault_ovf_r <= 1'b0;
            fault_unf_r <= 1'b0;
        end else if (fault_clr_s) begin
            fault_r     <= 1'b0;
            fault_ovf_r <= 1'b0;
            fault_unf_r <= 1'b0;
        end else if (ovf_set_s) begin
            fault_r     <= 1'b1;
            fault_ovf_r <= 1'b1;
        end else if (unf_set_s) begin
            fault_r     <= 1'b1;
            fault_unf_r <= 1'b1;
        end
    end

    assign cmd_ready  = cmd_ready_r;
    assign fetch_req  = fetch_req_r;
    assign fetch_addr = pc_r;
    assign pc         = pc_r;
    assign pc_prev    = pc_prev_r;
    assign fault      = fault_r;
    assign fault_ovf  = fault_ovf_r;
    assign fault_unf  = fault_unf_r;

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Self-checking bench for pc_flow_ctrl: vector table, fetch scoreboard and corner-case sequences.
module tb_pc_flow_ctrl;

`ifdef PCF_STACK_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [10:0] cmd_addr;
    logic [9:0]  cmd_rel;
    logic        fetch_req;
    logic [10:0] fetch_addr;
    logic        fetch_ack;
    logic [10:0] pc;
    logic [10:0] pc_prev;
    logic        fault;
    logic        fault_ovf;
    logic        fault_unf;
    logic        clear_fault;

    pc_flow_ctrl #(.AW(11), .RW(10), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_rel(cmd_rel),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
        .pc(pc), .pc_prev(pc_prev), .fault(fault), .fault_ovf(fault_ovf),
        .fault_unf(fault_unf), .clear_fault(clear_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  op;
        logic [10:0] addr;
        logic [9:0]  rel;
        logic [10:0] exp_pc;
        logic [10:0] exp_prev;
    } vec_t;

    vec_t        vt [11];
    logic [10:0] exp_q [$];
    logic [10:0] m_stk [$];
    logic [10:0] m_pc;
    logic [10:0] m_prev;
    int          n_chk;
    int          n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic model_reset();
        m_pc   = 11'd0;
        m_prev = 11'd0;
        m_stk.delete();
    endtask

    // Reference model of one accepted command.
    task automatic model_step(input logic [1:0] op, input logic [10:0] addr, input logic [9:0] rel,
                              output logic [10:0] epc, output logic [10:0] eprev,
                              output logic eovf, output logic eunf);
        logic [10:0] r;
        epc   = m_pc;
        eprev = m_prev;
        eovf  = 1'b0;
        eunf  = 1'b0;
        case (op)
            2'd0: begin eprev = m_pc; epc = m_pc + 11'd1; end
            2'd1: begin eprev = m_pc; epc = addr; end
            2'd2: begin
                if (m_stk.size() >= CAP) begin
                    eovf = 1'b1;
                end else begin
                    m_stk.push_back(m_pc);
                    eprev = m_pc;
                    epc   = m_pc + {1'b0, rel};
                end
            end
            default: begin
                if (m_stk.size() == 0) begin
                    eunf = 1'b1;
                end else begin
                    r     = m_stk.pop_back();
                    eprev = m_pc;
                    epc   = r + 11'd1;
                end
            end
        endcase
        m_pc   = epc;
        m_prev = eprev;
    endtask

    // Acknowledge the next fetch and check its address against the scoreboard.
    task automatic service_fetch(input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            if (fetch_req === 1'b1) begin
                got = 1'b1;
                if (exp_q.size() == 0) begin
                    fail_now("sb_unexpected_fetch");
                end else begin
                    chk("fetch_addr", {21'd0, fetch_addr}, {21'd0, exp_q.pop_front()});
                end
                fetch_ack = 1'b1;
                @(negedge clk);
                fetch_ack = 1'b0;
                chk("fetch_req_drop", {31'd0, fetch_req}, 32'd0);
                chk("ready_after_ack", {31'd0, cmd_ready}, 32'd1);
            end else begin
                @(negedge clk);
            end
        end
        if (!got) fail_now("fetch_timeout");
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 10 && cmd_ready !== 1'b1; i++) @(negedge clk);
        if (cmd_ready !== 1'b1) fail_now("ready_timeout");
    endtask

    // Issue one command and check the resulting architectural state.
    task automatic send(input logic [1:0] op, input logic [10:0] addr, input logic [9:0] rel,
                        input logic [10:0] epc, input logic [10:0] eprev,
                        input logic eovf, input logic eunf);
        wait_ready();
        if (!(eovf || eunf)) exp_q.push_back(epc);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_rel   = rel;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("pc", {21'd0, pc}, {21'd0, epc});
        chk("pc_prev", {21'd0, pc_prev}, {21'd0, eprev});
        chk("fault", {31'd0, fault}, {31'd0, eovf | eunf});
        chk("fault_ovf", {31'd0, fault_ovf}, {31'd0, eovf});
        chk("fault_unf", {31'd0, fault_unf}, {31'd0, eunf});
        chk("ready_busy", {31'd0, cmd_ready}, 32'd0);
        chk("fetch_req_new", {31'd0, fetch_req}, {31'd0, !(eovf | eunf)});
        if (!(eovf || eunf)) service_fetch(10);
    endtask

    task automatic run(input logic [1:0] op, input logic [10:0] addr, input logic [9:0] rel);
        logic [10:0] epc, eprev;
        logic        eovf, eunf;
        model_step(op, addr, rel, epc, eprev, eovf, eunf);
        send(op, addr, rel, epc, eprev, eovf, eunf);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pc", {21'd0, pc}, 32'd0);
        chk("rst_pc_prev", {21'd0, pc_prev}, 32'd0);
        chk("rst_fetch_req", {31'd0, fetch_req}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_fault", {29'd0, fault, fault_ovf, fault_unf}, 32'd0);
        rst_n = 1'b1;
        model_reset();
        exp_q.push_back(11'd0);
        service_fetch(5);
    endtask

    task automatic clear_and_check();
        clear_fault = 1'b1;
        @(negedge clk);
        clear_fault = 1'b0;
        chk("clr_fault", {29'd0, fault, fault_ovf, fault_unf}, 32'd0);
        chk("clr_ready", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        logic [10:0] epc, eprev;
        logic        eovf, eunf;
        int          nest;
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 11'd0; cmd_rel = 10'd0;
        fetch_ack = 1'b0; clear_fault = 1'b0;
        model_reset();

        vt[0]  = '{2'd0, 11'd0,    10'd0,   11'd1,    11'd0};
        vt[1]  = '{2'd0, 11'd0,    10'd0,   11'd2,    11'd1};
        vt[2]  = '{2'd0, 11'd0,    10'd0,   11'd3,    11'd2};
        vt[3]  = '{2'd1, 11'd2047, 10'd0,   11'd2047, 11'd3};
        vt[4]  = '{2'd0, 11'd0,    10'd0,   11'd0,    11'd2047};
        vt[5]  = '{2'd1, 11'd10,   10'd0,   11'd10,   11'd0};
        vt[6]  = '{2'd2, 11'd0,    10'd5,   11'd15,   11'd10};
        vt[7]  = '{2'd3, 11'd0,    10'd0,   11'd11,   11'd15};
        vt[8]  = '{2'd1, 11'd2000, 10'd0,   11'd2000, 11'd11};
        vt[9]  = '{2'd2, 11'd0,    10'd100, 11'd52,   11'd2000};
        vt[10] = '{2'd3, 11'd0,    10'd0,   11'd2001, 11'd52};

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 11; i++) begin
            model_step(vt[i].op, vt[i].addr, vt[i].rel, epc, eprev, eovf, eunf);
            send(vt[i].op, vt[i].addr, vt[i].rel, vt[i].exp_pc, vt[i].exp_prev, 1'b0, 1'b0);
        end

        // Nested calls unwind in LIFO order.
        nest = (CAP >= 3) ? 3 : 1;
        for (int i = 0; i < nest; i++) run(2'd2, 11'd0, 10'(i + 1));
        for (int i = 0; i < nest; i++) run(2'd3, 11'd0, 10'd0);

        // Overflow: one CALL beyond capacity faults and freezes state.
        for (int i = 0; i <= CAP; i++) run(2'd2, 11'd0, 10'd3);
        cmd_valid = 1'b1; cmd_op = 2'd0;
        repeat (2) @(negedge clk);
        cmd_valid = 1'b0;
        chk("fault_frozen_pc", {21'd0, pc}, {21'd0, m_pc});
        chk("fault_frozen_prev", {21'd0, pc_prev}, {21'd0, m_prev});
        chk("fault_no_fetch", {31'd0, fetch_req}, 32'd0);
        chk("fault_sticky", {31'd0, fault_ovf}, 32'd1);
        clear_and_check();
        for (int i = 0; i < CAP; i++) run(2'd3, 11'd0, 10'd0);

        // clear_fault and fetch_ack outside their states have no effect.
        clear_fault = 1'b1; fetch_ack = 1'b1;
        @(negedge clk);
        clear_fault = 1'b0; fetch_ack = 1'b0;
        chk("idle_ready_kept", {31'd0, cmd_ready}, 32'd1);
        chk("idle_no_fetch", {31'd0, fetch_req}, 32'd0);
        chk("idle_pc_kept", {21'd0, pc}, {21'd0, m_pc});

        // Stalled fetch: request held, commands during ISSUE ignored.
        wait_ready();
        model_step(2'd0, 11'd0, 10'd0, epc, eprev, eovf, eunf);
        exp_q.push_back(epc);
        cmd_valid = 1'b1; cmd_op = 2'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_fetch_req", {31'd0, fetch_req}, 32'd1);
            cmd_valid = (i == 1 || i == 2);
            cmd_op = 2'd1; cmd_addr = 11'd5;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        service_fetch(3);
        chk("stall_pc", {21'd0, pc}, {21'd0, epc});
        chk("stall_prev", {21'd0, pc_prev}, {21'd0, eprev});

        // Reset in the middle of ISSUE drops fetch_req immediately.
        wait_ready();
        cmd_valid = 1'b1; cmd_op = 2'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("pre_rst_fetch_req", {31'd0, fetch_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_fetch_req", {31'd0, fetch_req}, 32'd0);
        chk("async_rst_pc", {21'd0, pc}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        exp_q.push_back(11'd0);
        service_fetch(5);

        // RET straight after reset underflows.
        run(2'd3, 11'd0, 10'd0);
        clear_and_check();
        run(2'd0, 11'd0, 10'd0);

        if (exp_q.size() != 0) fail_now("sb_leftover");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
